rx_fifo: RTL and testbench

Byte-wide receive FIFO between the UART receiver's byte strobe and the PicoRV32 memory bus. Buffers incoming bytes so the CPU can drain them in bursts. Presents a two-word register window: data pops, status reports fill and overflow. Raises a level interrupt at a fill threshold.

---
 rtl/rx_fifo.sv | 154 +++++++++++++++
 tb/tb_rx_fifo.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rx_fifo.sv
// rx_fifo: byte-wide receive FIFO between the UART byte strobe and the
// PicoRV32 memory bus. Two-word register window (DATA pops, STATUS reports
// fill/overflow and accepts clear/flush) with one wait state per access.
// Optional level interrupt at a fill threshold, enabled by defining the
// macro RX_FIFO_IRQ_EN; without it irq is tied low.
module rx_fifo #(
  parameter int DEPTH         = 16,
  parameter int IRQ_THRESHOLD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        cs,
  input  logic        addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  // Parameter sanity checks at elaboration.
  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rx_fifo: DEPTH must be a power of two in 2..256");
  end
  if (IRQ_THRESHOLD < 1 || IRQ_THRESHOLD > DEPTH) begin : g_bad_thr
    $error("rx_fifo: IRQ_THRESHOLD must be in 1..DEPTH");
  end

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic          full, empty;
  logic          access, pop, st_wr, flush, clr_ovf;
  logic          push_ok, push_drop;
  logic [31:0]   rdata_next;
  logic          unused_bits;

  // Only wstrb[0] and wdata[1:0] carry meaning on the STATUS write.
  assign unused_bits = ^{wstrb[3:1], wdata[31:2]};

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign ready = (state == ACK);

  // Access strobes: the access happens on the edge where IDLE sees cs.
  assign pop     = access && !addr && (wstrb == 4'b0) && !empty;
  assign st_wr   = access && addr && wstrb[0];
  assign flush   = st_wr && wdata[1];
  assign clr_ovf = st_wr && wdata[0];

  // A flush discards the incoming byte without flagging overflow; a
  // concurrent pop frees the slot, so a full FIFO still accepts.
  assign push_ok   = wr_en && !flush && (!full || pop);
  assign push_drop = wr_en && !flush && full && !pop;

  // Bus state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Bus next-state: one access per transaction, cs ignored while acking.
  always_comb begin
    state_next = state;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (cs) begin
          access     = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data for the access being performed; writes return zero.
  // Count is truncated to 8 bits, so DEPTH=256 shows 0 there with full set.
  always_comb begin
    rdata_next = '0;
    if (wstrb == 4'b0) begin
      if (!addr) begin
        if (!empty) rdata_next = {23'b0, 1'b1, mem[rd_ptr]};
      end else begin
        rdata_next = {16'b0, 8'(count), 5'b0, ovf, full, empty};
      end
    end
  end

  // Registered read data, held until the next access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rdata <= '0;
    else if (access) rdata <= rdata_next;
  end

  // Byte storage; no reset needed, entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers and fill count; flush overrides any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear leaves it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ovf <= 1'b0;
    else if (push_drop) ovf <= 1'b1;
    else if (clr_ovf)   ovf <= 1'b0;
  end

`ifdef RX_FIFO_IRQ_EN
  localparam logic [AW:0] THR_CNT = (AW+1)'(IRQ_THRESHOLD);

  // Threshold interrupt, registered from the pre-edge count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= (count >= THR_CNT);
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Directed self-checking bench for rx_fifo (DEPTH=16, IRQ_THRESHOLD=4).
module tb_rx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        cs;
  logic        addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

`ifdef RX_FIFO_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  rx_fifo #(.DEPTH(16), .IRQ_THRESHOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .cs      (cs),
    .addr    (addr),
    .wstrb   (wstrb),
    .wdata   (wdata),
    .ready   (ready),
    .rdata   (rdata),
    .irq     (irq)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One push; starts and ends just after a falling edge.
  task automatic push(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One bus transaction, optionally with a push on the sampling edge.
  task automatic bus(input logic a, input logic [3:0] ws, input logic [31:0] wd,
                     input logic do_push, input logic [7:0] b, output logic [31:0] rd);
    cs = 1'b1; addr = a; wstrb = ws; wdata = wd;
    wr_en = do_push; wr_data = b;
    @(negedge clk);
    cs = 1'b0; wr_en = 1'b0;
    check("ready_hi", {31'b0, ready}, 32'd1);
    rd = rdata;
    @(negedge clk);
    check("ready_lo", {31'b0, ready}, 32'd0);
  endtask

  task automatic rd_data(output logic [31:0] rd);
    bus(1'b0, 4'h0, 32'h0, 1'b0, 8'h00, rd);
  endtask

  task automatic rd_stat(output logic [31:0] rd);
    bus(1'b1, 4'h0, 32'h0, 1'b0, 8'h00, rd);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    cs = 1'b0; addr = 1'b0; wstrb = 4'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq",   {31'b0, irq}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Empty status after reset.
    rd_stat(r);  check("stat_reset", r, 32'h0000_0001);
    check("irq_reset", {31'b0, irq}, 32'd0);

    // Basic push/pop ordering and empty read.
    push(8'h41); push(8'h42);
    rd_data(r);  check("pop_41", r, 32'h0000_0141);
    rd_data(r);  check("pop_42", r, 32'h0000_0142);
    rd_data(r);  check("pop_empty", r, 32'h0000_0000);
    rd_stat(r);  check("stat_empty", r, 32'h0000_0001);

    // Interrupt threshold at 4 entries.
    push(8'h10); push(8'h11); push(8'h12);
    @(negedge clk);
    check("irq_cnt3", {31'b0, irq}, 32'd0);
    push(8'h13);
    check("irq_lag", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("irq_cnt4", {31'b0, irq}, {31'b0, IRQ_ON});
    rd_data(r);  check("pop_10", r, 32'h0000_0110);
    check("irq_after_pop", {31'b0, irq}, 32'd0);
    rd_data(r);  check("pop_11", r, 32'h0000_0111);
    rd_data(r);  check("pop_12", r, 32'h0000_0112);
    rd_data(r);  check("pop_13", r, 32'h0000_0113);

    // Overflow: 17 pushes into 16 entries.
    for (int i = 0; i < 17; i++) push(8'(8'h20 + i));
    rd_stat(r);  check("stat_ovf", r, 32'h0000_1006);
    check("irq_full", {31'b0, irq}, {31'b0, IRQ_ON});
    bus(1'b1, 4'h1, 32'h1, 1'b0, 8'h00, r);
    rd_stat(r);  check("stat_ovf_clr", r, 32'h0000_1002);

    // Full FIFO, push on the same edge as a pop: accepted, no overflow.
    bus(1'b0, 4'h0, 32'h0, 1'b1, 8'h99, r);
    check("pop_full_oldest", r, 32'h0000_0120);
    rd_stat(r);  check("stat_full_pp", r, 32'h0000_1002);
    for (int i = 1; i < 16; i++) begin
      rd_data(r);
      check("drain", r, 32'h0000_0100 | 32'(8'h20 + i));
    end
    rd_data(r);  check("drain_last_99", r, 32'h0000_0199);
    rd_data(r);  check("drain_empty", r, 32'h0000_0000);

    // Push + pop at count = 1.
    push(8'h55);
    bus(1'b0, 4'h0, 32'h0, 1'b1, 8'h66, r);
    check("pop_55", r, 32'h0000_0155);
    rd_stat(r);  check("stat_cnt1", r, 32'h0000_0100);
    rd_data(r);  check("pop_66", r, 32'h0000_0166);

    // Flush with a concurrent push: flush wins, no overflow.
    for (int i = 0; i < 5; i++) push(8'(8'h70 + i));
    bus(1'b1, 4'h1, 32'h2, 1'b1, 8'hEE, r);
    rd_stat(r);  check("stat_flush", r, 32'h0000_0001);
    rd_data(r);  check("pop_after_flush", r, 32'h0000_0000);

    // Data write has no effect.
    push(8'h33);
    bus(1'b0, 4'hF, 32'hFFFF_FFFF, 1'b0, 8'h00, r);
    rd_stat(r);  check("stat_data_wr", r, 32'h0000_0100);

    // Reset in the middle of a transaction aborts the ready pulse.
    cs = 1'b1; addr = 1'b1; wstrb = 4'h0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_mid_ready", {31'b0, ready}, 32'd0);
    cs = 1'b0;
    @(negedge clk);
    check("rst_mid_ready2", {31'b0, ready}, 32'd0);
    check("rst_mid_rdata", rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    rd_stat(r);  check("stat_after_rst", r, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
